vx_axi_read_credit_ctrl: RTL and testbench

Outstanding-read credit controller between the AXI read arbiter's master port and the memory slave. Tracks in-flight read bursts globally and per requester, decoding the requester from the arbiter-inserted select bits in ARID. Stalls AR when credits run out and provides a drain/quiesce handshake for flush and reset sequencing. R channel is a zero-latency pass-through; only the counters observe it.

---
 rtl/vx_axi_pkg.sv | 40 ++++
 rtl/vx_credit_counter.sv | 43 ++++
 rtl/vx_axi_read_credit_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_vx_axi_read_credit_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_axi_pkg.sv
// Shared types for the AXI read credit controller.
//   ar_misc_t     : AR sideband fields {lock,cache,prot,qos,region}, 17 bits
//   axi_resp_e    : AXI response codes
//   drain_state_e : drain/quiesce state machine encoding
//   sel_bits()    : width of the requester select field in ARID/RID
package vx_axi_pkg;

  localparam int unsigned AR_MISC_W = 17;

  typedef struct packed {
    logic [1:0] lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } ar_misc_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  typedef enum logic [1:0] {
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    HELD  = ST_HELD
  } drain_state_e;

  // A single requester still gets a 1-bit (constant zero) select.
  function automatic int unsigned sel_bits(input int unsigned num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

endpackage

// File: rtl/vx_credit_counter.sv
// Saturating up/down credit counter.
//   clk, rst_n  : clock, async active-low reset
//   inc_i/dec_i : count up / down this cycle (both together = no change)
//   count_o     : current count
//   at_limit_o  : count has reached LIMIT
module vx_credit_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_limit_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Saturate at LIMIT going up and at zero going down.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q < WIDTH'(LIMIT))) begin
      count_d = count_q + WIDTH'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o    = count_q;
  assign at_limit_o = (count_q >= WIDTH'(LIMIT));

  // A retire with nothing outstanding is an upstream protocol violation.
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
                                    !(dec_i && !inc_i && (count_q == '0)))
    else $error("vx_credit_counter: decrement while count is zero");

endmodule

// File: rtl/vx_axi_read_credit_ctrl.sv
// Outstanding-read credit controller between the read arbiter and memory.
// Tracks in-flight bursts globally and per requester (select bits in ARID/RID),
// stalls AR when credits are exhausted, and offers a drain/quiesce handshake.
// AR and R channels are combinational pass-throughs.
//   clk, reset          : clock, async active-low reset
//   s_ar* / m_ar*       : upstream / downstream AR channel
//   m_r* / s_r*         : downstream / upstream R channel
//   drain_req/drain_ack : level drain request / drained indication
//   pending_total       : global in-flight burst count
//   pending_req         : per-requester counts, requester i at [i*REQ_W +: REQ_W]
//   busy                : any burst in flight
//   timeout_err         : sticky watchdog flag (VX_AXI_RD_TIMEOUT_EN), else 0
// Optional: define VX_AXI_RD_TIMEOUT_EN to build the watchdog.
module vx_axi_read_credit_ctrl
  import vx_axi_pkg::*;
#(
  parameter int unsigned NUM_REQS        = 2,
  parameter int unsigned ID_WIDTH        = 5,
  parameter int unsigned SEL_IDX         = 0,
  parameter int unsigned MAX_PENDING     = 16,
  parameter int unsigned MAX_PENDING_REQ = 8,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  localparam int unsigned TOT_W = $clog2(MAX_PENDING + 1),
  localparam int unsigned REQ_W = $clog2(MAX_PENDING_REQ + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  // upstream AR
  input  logic                      s_arvalid,
  output logic                      s_arready,
  input  logic [ADDR_WIDTH-1:0]     s_araddr,
  input  logic [ID_WIDTH-1:0]       s_arid,
  input  logic [7:0]                s_arlen,
  input  logic [2:0]                s_arsize,
  input  logic [1:0]                s_arburst,
  input  ar_misc_t                  s_ar_misc,
  // downstream AR
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic [ID_WIDTH-1:0]       m_arid,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  output ar_misc_t                  m_ar_misc,
  // downstream R
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic                      m_rlast,
  input  logic [ID_WIDTH-1:0]       m_rid,
  input  logic [1:0]                m_rresp,
  // upstream R
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic                      s_rlast,
  output logic [ID_WIDTH-1:0]       s_rid,
  output logic [1:0]                s_rresp,
  // control / status
  input  logic                      drain_req,
  output logic                      drain_ack,
  output logic [TOT_W-1:0]          pending_total,
  output logic [NUM_REQS*REQ_W-1:0] pending_req,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned SEL_W    = sel_bits(NUM_REQS);
  localparam int unsigned SEL_SPAN = 1 << SEL_W;

  drain_state_e        state_q, state_d;
  logic [SEL_W-1:0]    ar_sel, r_sel;
  logic [SEL_SPAN-1:0] req_full;
  logic                glob_full;
  logic                grant;
  logic                issue, retire;

  // Requester select decode; no ID bits are looked at for a single requester.
  if (NUM_REQS > 1) begin : g_sel
    assign ar_sel = s_arid[SEL_IDX +: SEL_W];
    assign r_sel  = m_rid[SEL_IDX +: SEL_W];
  end else begin : g_nosel
    assign ar_sel = '0;
    assign r_sel  = '0;
  end

  // Grant uses registered state only, so m_arready never loops back into it.
  assign grant = reset && (state_q == RUN) && !glob_full && !req_full[ar_sel];

  assign m_arvalid = s_arvalid & grant;
  assign s_arready = m_arready & grant;
  assign m_araddr  = s_araddr;
  assign m_arid    = s_arid;
  assign m_arlen   = s_arlen;
  assign m_arsize  = s_arsize;
  assign m_arburst = s_arburst;
  assign m_ar_misc = s_ar_misc;

  assign s_rvalid = m_rvalid;
  assign m_rready = s_rready;
  assign s_rdata  = m_rdata;
  assign s_rlast  = m_rlast;
  assign s_rid    = m_rid;
  assign s_rresp  = m_rresp;

  assign issue  = m_arvalid & m_arready;
  assign retire = m_rvalid & s_rready & m_rlast;

  // Global credit pool.
  vx_credit_counter #(
    .WIDTH (TOT_W),
    .LIMIT (MAX_PENDING)
  ) u_cnt_total (
    .clk        (clk),
    .rst_n      (reset),
    .inc_i      (issue),
    .dec_i      (retire),
    .count_o    (pending_total),
    .at_limit_o (glob_full)
  );

  // Per-requester credit pools.
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_req
    vx_credit_counter #(
      .WIDTH (REQ_W),
      .LIMIT (MAX_PENDING_REQ)
    ) u_cnt_req (
      .clk        (clk),
      .rst_n      (reset),
      .inc_i      (issue  && (ar_sel == SEL_W'(i))),
      .dec_i      (retire && (r_sel  == SEL_W'(i))),
      .count_o    (pending_req[i*REQ_W +: REQ_W]),
      .at_limit_o (req_full[i])
    );
  end

  // Select codes with no requester behind them are never granted.
  if (SEL_SPAN > NUM_REQS) begin : g_pad
    assign req_full[SEL_SPAN-1:NUM_REQS] = '1;
  end

  // Drain FSM; entry from RUN waits until no AR is left hanging on m_ar*.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req && (!m_arvalid || m_arready)) state_d = DRAIN;
      DRAIN: begin
        if (!drain_req)                state_d = RUN;
        else if (pending_total == '0)  state_d = HELD;
      end
      HELD:    if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign drain_ack = (state_q == HELD);
  assign busy      = (pending_total != '0);

`ifdef VX_AXI_RD_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;

  // Watchdog: counts busy cycles without forward progress; flag is sticky.
  always_comb begin
    wd_d = wd_q;
    to_d = to_q;
    if (retire || !busy) begin
      wd_d = '0;
    end else if (wd_q < WD_W'(TIMEOUT_CYCLES)) begin
      wd_d = wd_q + WD_W'(1);
    end
    if (busy && !retire && (wd_q == WD_W'(TIMEOUT_CYCLES - 1))) to_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign timeout_err = to_q;

  a_no_timeout : assert property (@(posedge clk) disable iff (!reset)
                                  !(to_d && !to_q))
    else $error("vx_axi_read_credit_ctrl: read response watchdog expired");
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_vx_axi_read_credit_ctrl.sv
// Self-checking bench for vx_axi_read_credit_ctrl: directed vector table,
// hand-written multi-cycle sequences and randomized traffic against a
// count-based reference model.
module tb_vx_axi_read_credit_ctrl;

  localparam int NR  = 2;
  localparam int IDW = 5;
  localparam int MP  = 4;
  localparam int MPR = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TW  = 3;
  localparam int RW  = 2;

  logic clk = 1'b0;
  logic reset;

  logic           s_arvalid, s_arready;
  logic [AW-1:0]  s_araddr,  m_araddr;
  logic [IDW-1:0] s_arid,    m_arid;
  logic [7:0]     s_arlen,   m_arlen;
  logic [2:0]     s_arsize,  m_arsize;
  logic [1:0]     s_arburst, m_arburst;
  logic [16:0]    s_ar_misc, m_ar_misc;
  logic           m_arvalid, m_arready;
  logic           m_rvalid,  m_rready,  m_rlast;
  logic [DW-1:0]  m_rdata,   s_rdata;
  logic [IDW-1:0] m_rid,     s_rid;
  logic [1:0]     m_rresp,   s_rresp;
  logic           s_rvalid,  s_rready,  s_rlast;
  logic           drain_req, drain_ack, busy, timeout_err;
  logic [TW-1:0]  pending_total;
  logic [NR*RW-1:0] pending_req;

  vx_axi_read_credit_ctrl #(
    .NUM_REQS(NR), .ID_WIDTH(IDW), .SEL_IDX(0), .MAX_PENDING(MP),
    .MAX_PENDING_REQ(MPR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_ar_misc(s_ar_misc),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_ar_misc(m_ar_misc),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .m_rid(m_rid), .m_rresp(m_rresp),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
    .s_rid(s_rid), .s_rresp(s_rresp),
    .drain_req(drain_req), .drain_ack(drain_ack), .pending_total(pending_total),
    .pending_req(pending_req), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic arv; logic ars; logic ardy;
    logic rv;  logic rl;  logic rs;  logic rr;
    logic drq;
    logic gnt; int tot; int p0; int p1; logic ack;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic arv, input logic ars, input logic ardy, input logic rv,
                       input logic rl, input logic rs, input logic rr, input logic drq);
    s_arvalid = arv;
    s_arid    = {4'($urandom()), ars};
    m_arready = ardy;
    m_rvalid  = rv;
    m_rlast   = rl;
    m_rid     = {4'($urandom()), rs};
    s_rready  = rr;
    drain_req = drq;
    s_araddr  = $urandom();
    s_arlen   = 8'($urandom());
    s_arsize  = 3'($urandom());
    s_arburst = 2'($urandom());
    s_ar_misc = 17'($urandom());
    m_rdata   = $urandom();
    m_rresp   = 2'($urandom());
  endtask

  // Compare all observable outputs against the expected grant/counts/ack.
  task automatic check_outs(input string tag, input logic gnt, input int tot,
                            input int p0, input int p1, input logic ack);
    chk({tag, " s_arready"},     64'(s_arready),       64'(m_arready & gnt));
    chk({tag, " m_arvalid"},     64'(m_arvalid),       64'(s_arvalid & gnt));
    chk({tag, " pending_total"}, 64'(pending_total),   64'(tot));
    chk({tag, " pending_req0"},  64'(pending_req[RW-1:0]),    64'(p0));
    chk({tag, " pending_req1"},  64'(pending_req[2*RW-1:RW]), 64'(p1));
    chk({tag, " busy"},          64'(busy),            64'(tot != 0));
    chk({tag, " drain_ack"},     64'(drain_ack),       64'(ack));
    chk({tag, " m_rready"},      64'(m_rready),        64'(s_rready));
    chk({tag, " s_rvalid"},      64'(s_rvalid),        64'(m_rvalid));
    chk({tag, " ar_payload"},    64'({m_araddr, m_arid, m_arlen, m_arsize, m_arburst}),
                                 64'({s_araddr, s_arid, s_arlen, s_arsize, s_arburst}));
    chk({tag, " ar_misc"},       64'(m_ar_misc),       64'(s_ar_misc));
    chk({tag, " r_payload"},     64'({s_rdata, s_rid, s_rresp, s_rlast}),
                                 64'({m_rdata, m_rid, m_rresp, m_rlast}));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1, 0, 1, 1, 1, 0, 1, 0);
    tick();
    @(negedge clk);
    check_outs("reset", 1'b0, 0, 0, 0, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
  endtask

  task automatic add(input logic arv, input logic ars, input logic ardy, input logic rv,
                     input logic rl, input logic rs, input logic rr, input logic drq,
                     input logic gnt, input int tot, input int p0, input int p1, input logic ack);
    vec_t v;
    v.arv = arv; v.ars = ars; v.ardy = ardy; v.rv = rv; v.rl = rl; v.rs = rs; v.rr = rr;
    v.drq = drq; v.gnt = gnt; v.tot = tot; v.p0 = p0; v.p1 = p1; v.ack = ack;
    vecs.push_back(v);
  endtask

  // Reference model state: counts per requester, drain mode 0=run 1=drain 2=held.
  int mp[NR];
  int mtot;
  int mode;

  initial begin
    vec_t v;
    string tag;

    //  arv ars ardy rv rl rs rr drq | gnt tot p0 p1 ack
    add(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0,   1, 2, 2, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0,   0, 3, 3, 0, 0);  // requester 0 at its limit
    add(1, 1, 1, 0, 0, 0, 0, 0,   1, 3, 3, 0, 0);  // requester 1 still granted
    add(1, 1, 1, 0, 0, 0, 0, 0,   0, 4, 3, 1, 0);  // global limit
    add(1, 1, 1, 1, 0, 0, 1, 0,   0, 4, 3, 1, 0);  // non-last beat
    add(1, 1, 1, 1, 1, 0, 1, 0,   0, 4, 3, 1, 0);  // retire, no same-cycle bypass
    add(1, 1, 1, 0, 0, 0, 0, 0,   1, 3, 2, 1, 0);  // freed credit usable now
    add(1, 0, 1, 1, 1, 1, 1, 0,   0, 4, 2, 2, 0);
    add(1, 0, 1, 1, 1, 0, 1, 0,   1, 3, 2, 1, 0);  // issue+retire same requester
    add(1, 1, 1, 1, 1, 0, 1, 0,   1, 3, 2, 1, 0);  // issue r1, retire r0
    add(0, 0, 0, 0, 0, 0, 0, 1,   1, 3, 1, 2, 0);  // drain with 3 pending
    add(1, 0, 1, 0, 0, 0, 0, 1,   0, 3, 1, 2, 0);
    add(1, 0, 1, 1, 1, 0, 1, 1,   0, 3, 1, 2, 0);
    add(0, 0, 0, 1, 1, 1, 1, 1,   0, 2, 0, 2, 0);
    add(0, 0, 0, 1, 1, 1, 1, 1,   0, 1, 0, 1, 0);  // last rlast
    add(1, 0, 1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1);  // drained
    add(1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);  // drain_req falls
    add(1, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0);  // ARs resume
    add(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1,   1, 1, 1, 0, 0);  // presented AR: drain deferred
    add(1, 0, 0, 0, 0, 0, 0, 1,   1, 1, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 1,   1, 1, 1, 0, 0);  // handshake, drain entered
    add(1, 0, 1, 0, 0, 0, 0, 1,   0, 2, 2, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 2, 2, 0, 0);  // drop drain before drained
    add(0, 0, 0, 0, 0, 0, 0, 0,   1, 2, 2, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0,   1, 2, 2, 0, 0);  // rlast without rready
    add(0, 0, 0, 0, 0, 0, 0, 0,   1, 2, 2, 0, 0);
    add(0, 0, 0, 1, 1, 0, 1, 1,   1, 2, 2, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 0);  // mid-drain

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.arv, v.ars, v.ardy, v.rv, v.rl, v.rs, v.rr, v.drq);
      @(negedge clk);
      tag = $sformatf("vec%0d", i);
      check_outs(tag, v.gnt, v.tot, v.p0, v.p1, v.ack);
      tick();
    end

    // Asynchronous reset while draining with one burst pending.
    drive(1, 0, 1, 0, 0, 0, 0, 1);
    reset = 1'b0;
    #1;
    check_outs("async_rst_drain", 1'b0, 0, 0, 0, 1'b0);
    @(negedge clk);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check_outs("post_rst_run", 1'b1, 0, 0, 0, 1'b0);
    tick();

    // Reach HELD, then reset asynchronously: drain_ack drops at once.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    @(negedge clk);
    check_outs("held", 1'b0, 0, 0, 0, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    check_outs("async_rst_held", 1'b0, 0, 0, 0, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Four-beat burst: counters move only on the rlast beat.
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    s_arlen = 8'd3;
    tick();
    for (int b = 0; b < 4; b++) begin
      drive(0, 0, 0, 1, logic'(b == 3), 1, 1, 0);
      @(negedge clk);
      check_outs($sformatf("burst_beat%0d", b), 1'b1, 1, 0, 1, 1'b0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_outs("burst_done", 1'b1, 0, 0, 0, 1'b0);
    tick();

    // Randomized traffic against the count model.
    do_reset();
    mp = '{default: 0};
    mtot = 0;
    mode = 0;
    begin
      logic drq = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        logic arv, ars, ardy, rv, rl, rs, rr, g, iss, ret;
        arv  = logic'($urandom_range(0, 1));
        ars  = logic'($urandom_range(0, 1));
        ardy = logic'($urandom_range(0, 3) != 0);
        rv   = logic'($urandom_range(0, 1));
        rs   = logic'($urandom_range(0, 1));
        rl   = logic'($urandom_range(0, 2) == 0);
        if (mp[rs] == 0) rl = 1'b0;
        rr   = logic'($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 49) == 0) drq = ~drq;
        drive(arv, ars, ardy, rv, rl, rs, rr, drq);
        g = logic'(mode == 0 && mtot < MP && mp[ars] < MPR);
        @(negedge clk);
        check_outs($sformatf("rand%0d", c), g, mtot, mp[0], mp[1], logic'(mode == 2));
        iss = arv & g & ardy;
        ret = rv & rl & rr;
        case (mode)
          0: if (drq && (!(arv && g) || ardy)) mode = 1;
          1: if (!drq) mode = 0; else if (mtot == 0) mode = 2;
          default: if (!drq) mode = 0;
        endcase
        if (iss) begin mp[ars]++; mtot++; end
        if (ret) begin mp[rs]--; mtot--; end
        tick();
      end
    end

`ifdef VX_AXI_RD_TIMEOUT_EN
    // Watchdog: one AR never answered, flag is sticky across the late response.
    do_reset();
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (9) tick();
    @(negedge clk);
    chk("timeout_early", 64'(timeout_err), 64'(0));
    repeat (10) tick();
    @(negedge clk);
    chk("timeout_set", 64'(timeout_err), 64'(1));
    tick();
    drive(0, 0, 0, 1, 1, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("timeout_sticky", 64'(timeout_err), 64'(1));
    chk("timeout_drained", 64'(pending_total), 64'(0));
`else
    @(negedge clk);
    chk("timeout_tied", 64'(timeout_err), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

endmodule
